// File: rtl/nibble_serial_adder.sv
// Serial adder: walks two W-bit operands one nibble per cycle through an
// external 4-bit ripple-carry adder, chaining the carry between nibbles.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_carry
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IW'(n)) begin
                        sum_d[4*n +: 4] = add_sum;
                    end
                end
                carry_d = add_carry;
                // The final nibble goes straight into result so no extra cycle is spent.
                if (idx_q == LAST_IDX) begin
                    result_d = sum_d;
                    cout_d   = add_carry;
                    idx_d    = '0;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_cin = carry_q;
            for (int n = 0; n < NIBBLES; n++) begin
                if (idx_q == IW'(n)) begin
                    add_a = a_q[4*n +: 4];
                    add_b = b_q[4*n +: 4];
                end
            end
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: an inline 4-bit adder stands in for the external
// ripple-carry block, and a queue of expected sums is drained on every done pulse.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic [3:0]    add_a;
    logic [3:0]    add_b;
    logic          add_cin;
    logic [3:0]    add_sum;
    logic          add_carry;

    int            compareCount  = 0;
    int            mismatchCount = 0;
    int            acceptCount   = 0;
    int            doneCount     = 0;
    logic [W:0]    sbQueue[$];
    logic          cinLog[NIBBLES];

    always #5 clk = ~clk;

    assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_carry(add_carry)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every done pulse retires the oldest outstanding expected sum.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            doneCount++;
            if (sbQueue.size() == 0) begin
                checkOutput("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                checkOutput("sb_sum", 32'({cout, result}), 32'(sbQueue.pop_front()));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        sbQueue.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
        acceptCount++;
        @(negedge clk);
        start = 1'b0;
        op_a  = W'($urandom);
        op_b  = W'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic finishOp(input bit detailed, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < NIBBLES + 8) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (detailed) begin
                    checkOutput("run_busy", 32'(busy), 32'd1);
                    if (n < NIBBLES) begin
                        cinLog[n] = add_cin;
                        checkOutput("run_add_a", 32'(add_a), 32'(a[4*n +: 4]));
                        checkOutput("run_add_b", 32'(add_b), 32'(b[4*n +: 4]));
                    end
                end
                op_a = W'($urandom);
                op_b = W'($urandom);
                cin  = 1'($urandom);
                @(negedge clk);
                n++;
            end
        end
        checkOutput("done_seen", 32'(seen), 32'd1);
        if (detailed) begin
            checkOutput("latency", 32'(n), 32'(NIBBLES));
            checkOutput("done_busy", 32'(busy), 32'd0);
            checkOutput("done_add_a", 32'(add_a), 32'd0);
            checkOutput("done_add_b", 32'(add_b), 32'd0);
            checkOutput("done_add_cin", 32'(add_cin), 32'd0);
        end
        @(negedge clk);
        if (detailed) begin
            checkOutput("done_pulse_width", 32'(done), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_sum", 32'({cout, result}), 32'd0);
        checkOutput("reset_add", 32'({add_cin, add_a, add_b}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic addition");
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        finishOp(1'b1, 16'h1234, 16'h4321);
        checkOutput("basic_sum", 32'({cout, result}), 32'h0_5555);

        $display("[TB] full carry ripple");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        finishOp(1'b1, 16'hFFFF, 16'h0001);
        checkOutput("ripple_sum", 32'({cout, result}), 32'h1_0000);
        checkOutput("ripple_cin0", 32'(cinLog[0]), 32'd0);
        checkOutput("ripple_cin1", 32'(cinLog[1]), 32'd1);
        checkOutput("ripple_cin2", 32'(cinLog[2]), 32'd1);
        checkOutput("ripple_cin3", 32'(cinLog[3]), 32'd1);

        $display("[TB] carry-in and top-bit overflow");
        applyStimulus(16'hFFFF, 16'h0000, 1'b1);
        finishOp(1'b1, 16'hFFFF, 16'h0000);
        checkOutput("cin_sum", 32'({cout, result}), 32'h1_0000);
        applyStimulus(16'h8000, 16'h8000, 1'b0);
        finishOp(1'b1, 16'h8000, 16'h8000);
        checkOutput("msb_sum", 32'({cout, result}), 32'h1_0000);

        $display("[TB] start held high, operands churning");
        op_a  = 16'h1111;
        op_b  = 16'h2222;
        cin   = 1'b1;
        start = 1'b1;
        sbQueue.push_back(17'h0_3334);
        acceptCount++;
        for (int i = 0; i < NIBBLES + 1; i++) begin
            @(negedge clk);
            op_a = W'($urandom);
            op_b = W'($urandom);
            cin  = 1'($urandom);
            if (i < NIBBLES) checkOutput("hold_busy", 32'(busy), 32'd1);
            else             checkOutput("hold_done", 32'(done), 32'd1);
        end
        op_a = 16'h0A0A;
        op_b = 16'h0505;
        cin  = 1'b0;
        @(negedge clk);
        checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
        checkOutput("result_holds", 32'({cout, result}), 32'h0_3334);
        sbQueue.push_back(17'h0_0F0F);
        acceptCount++;
        @(negedge clk);
        start = 1'b0;
        checkOutput("accept_after_done", 32'(busy), 32'd1);
        finishOp(1'b0, 16'h0A0A, 16'h0505);
        checkOutput("second_hold_sum", 32'({cout, result}), 32'h0_0F0F);

        $display("[TB] reset during RUN");
        applyStimulus(16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_sum", 32'({cout, result}), 32'd0);
        checkOutput("abort_add", 32'({add_cin, add_a, add_b}), 32'd0);
        sbQueue.delete();
        acceptCount--;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort_no_done", 32'(done), 32'd0);
        end
        applyStimulus(16'h00FF, 16'h0001, 1'b0);
        finishOp(1'b1, 16'h00FF, 16'h0001);
        checkOutput("post_reset_sum", 32'({cout, result}), 32'h0_0100);

        $display("[TB] random operations");
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            applyStimulus(ra, rb, rc);
            finishOp(1'b0, ra, rb);
        end

        checkOutput("done_count", 32'(doneCount), 32'(acceptCount));
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
